// File: rtl/gcd_pkg.sv
// gcd_pkg: shared constants for the GCD arbiter slice.
// Holds the controller state encoding and the default operand width and
// watchdog limit used by gcd_arbiter.
package gcd_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_MAX_CYC = 1024;

  // Controller states. Plain constants keep the encoding visible on the
  // debug state output and easy to compare against in checkers.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

endpackage

// File: rtl/gcd_rr_pick.sv
// gcd_rr_pick: combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with highest priority this round
//   grant - one-hot grant (all zero when req is zero)
//   idx   - index of the granted bit (0 when req is zero)
module gcd_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx
);

  logic found;
  int   j;

  // Scan from ptr upward, wrapping, and keep the first set bit.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one go/done GCD engine between N_REQ requesters.
// Requesters are served round-robin. Operands are latched on grant, the
// engine is cleared, launched and waited on, and the result is returned to
// the owning requester. Zero operands are answered directly without the
// engine, and a watchdog bounds the time spent waiting for eng_done.
// Ports:
//   clk, clr              - clock and synchronous active-high reset
//   req, x_in, y_in       - per-requester job request and operand slices
//   ack                   - one-cycle pulse when a job is accepted
//   rsp_valid, rsp_ready  - per-requester result handshake
//   rsp_data, rsp_err     - shared result bus, error = watchdog expiry
//   eng_clr, eng_go       - engine clear and start
//   eng_x, eng_y          - engine operands
//   eng_done, eng_g       - engine done level and result
//   state, ptr            - debug view of controller state and RR pointer
//
// Handshake: a result transfers on a cycle where rsp_valid[owner] and
// rsp_ready[owner] are both 1; until then rsp_valid and rsp_data hold.
// A job is accepted on the cycle ack[i] pulses; req is level and is only
// looked at in IDLE.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_CYC = DEF_MAX_CYC,
  parameter int TO_W    = $clog2(MAX_CYC) + 1,
  parameter int PTR_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] x_in,
  input  logic [N_REQ*WIDTH-1:0] y_in,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   eng_clr,
  output logic                   eng_go,
  output logic [WIDTH-1:0]       eng_x,
  output logic [WIDTH-1:0]       eng_y,
  input  logic                   eng_done,
  input  logic [WIDTH-1:0]       eng_g,
  output logic [2:0]             state,
  output logic [PTR_W-1:0]       ptr
);

  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] next_ptr;
  logic [N_REQ-1:0] owner_oh;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic [TO_W-1:0]  wd;

  gcd_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign sel_x    = x_in[gidx*WIDTH +: WIDTH];
  assign sel_y    = y_in[gidx*WIDTH +: WIDTH];
  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign next_ptr = (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;

  // Combinational so a reset in any state reaches the engine the same cycle.
  assign eng_clr = clr | (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      ptr       <= '0;
      owner     <= '0;
      ack       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_go    <= 1'b0;
      eng_x     <= '0;
      eng_y     <= '0;
      wd        <= '0;
    end else begin
      ack    <= '0;
      eng_go <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner <= gidx;
            ack   <= grant;
            eng_x <= sel_x;
            eng_y <= sel_y;
            // The engine never terminates on a zero operand; answer here.
            // With at least one zero, OR yields the other operand (or 0).
            if (sel_x == '0 || sel_y == '0) begin
              rsp_data <= sel_x | sel_y;
              rsp_err  <= 1'b0;
              state    <= S_RESP;
            end else begin
              state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          // eng_go is high for the whole LAUNCH cycle.
          eng_go <= 1'b1;
          state  <= S_LAUNCH;
        end
        S_LAUNCH: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so it wins over a same-cycle expiry.
          if (eng_done) begin
            rsp_data <= eng_g;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (wd == TO_W'(MAX_CYC - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_valid[owner] && rsp_ready[owner]) begin
            rsp_valid <= '0;
            ptr       <= next_ptr;
            state     <= S_IDLE;
          end else begin
            rsp_valid <= owner_oh;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed bench for gcd_arbiter with a behavioural
// subtraction GCD engine attached to the engine port.
module tb_gcd_arbiter;
  import gcd_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MC = 1024;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] req;
  logic [N*W-1:0] x_in;
  logic [N*W-1:0] y_in;
  logic [N-1:0] ack;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         eng_clr;
  logic         eng_go;
  logic [W-1:0] eng_x;
  logic [W-1:0] eng_y;
  logic         eng_done;
  logic [W-1:0] eng_g;
  logic [2:0]   state;
  logic [1:0]   ptr;

  int checks = 0;
  int fails  = 0;
  int ack_cnt, go_cnt, clr_cnt, wait_cnt;
  bit hang;

  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_CYC(MC)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .eng_clr   (eng_clr),
    .eng_go    (eng_go),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_done  (eng_done),
    .eng_g     (eng_g),
    .state     (state),
    .ptr       (ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural engine ----------------
  logic [W-1:0] ea, eb;
  logic         ebusy;
  always @(posedge clk) begin
    if (eng_clr) begin
      ebusy    <= 1'b0;
      eng_done <= 1'b0;
      eng_g    <= '0;
    end else if (eng_go) begin
      ea       <= eng_x;
      eb       <= eng_y;
      ebusy    <= 1'b1;
      eng_done <= 1'b0;
    end else if (ebusy && !hang) begin
      if (ea == eb) begin
        eng_done <= 1'b1;
        eng_g    <= ea;
        ebusy    <= 1'b0;
      end else if (ea > eb) begin
        ea <= ea - eb;
      end else begin
        eb <= eb - ea;
      end
    end
  end

  // ---------------- event counters (pre-edge values) ----------------
  always @(posedge clk) begin
    if (ack != '0)        ack_cnt++;
    if (eng_go)           go_cnt++;
    if (eng_clr)          clr_cnt++;
    if (state == S_WAIT)  wait_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_job(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req[i]         = 1'b1;
    x_in[i*W +: W] = x;
    y_in[i*W +: W] = y;
  endtask

  task automatic wait_ack(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ack[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid[i]) ok = 1'b1;
    end
  endtask

  task automatic finish_rsp(input int i);
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; req = '0; rsp_ready = '0; x_in = '0; y_in = '0; hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, rsp_valid, rsp_data, rsp_err, eng_go, eng_x, eng_y} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b vld=%b data=%0d err=%b go=%b x=%0d y=%0d, want all 0",
               ack, rsp_valid, rsp_data, rsp_err, eng_go, eng_x, eng_y);
    end
    checks++;
    if (eng_clr !== 1'b1) begin fails++; $display("FAIL reset_eng_clr: got %b want 1", eng_clr); end
    checks++;
    if (state !== S_IDLE || ptr !== 2'd0) begin
      fails++; $display("FAIL reset_state: got state=%0d ptr=%0d want 0/0", state, ptr);
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (eng_clr !== 1'b0) begin fails++; $display("FAIL reset_release: eng_clr got %b want 0", eng_clr); end
  endtask

  task automatic test_engine_job();
    bit ok;
    ack_cnt = 0; go_cnt = 0;
    set_job(1, 8'd12, 8'd18);
    wait_ack(1, ok);
    checks++;
    if (!ok || ack !== 4'b0010) begin fails++; $display("FAIL eng_ack: got ack=%b seen=%b want 0010", ack, ok); end
    req[1] = 1'b0;
    wait_rsp(1, 200, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL eng_rsp_timeout: got no rsp_valid[1] want rsp within 200 cycles"); end
    checks++;
    if (rsp_data !== 8'd6 || rsp_err !== 1'b0 || rsp_valid !== 4'b0010) begin
      fails++; $display("FAIL eng_result: got data=%0d err=%b vld=%b want 6/0/0010", rsp_data, rsp_err, rsp_valid);
    end
    checks++;
    if (ack_cnt != 1 || go_cnt != 1) begin
      fails++; $display("FAIL eng_pulses: got ack_cycles=%0d go_cycles=%0d want 1/1", ack_cnt, go_cnt);
    end
    finish_rsp(1);
    checks++;
    if (rsp_valid !== 4'b0000 || ptr !== 2'd2) begin
      fails++; $display("FAIL eng_release: got vld=%b ptr=%0d want 0000/2", rsp_valid, ptr);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] bx [2];
    logic [W-1:0] by [2];
    logic [W-1:0] be [2];
    bx[0] = 8'd0; by[0] = 8'd35; be[0] = 8'd35;
    bx[1] = 8'd0; by[1] = 8'd0;  be[1] = 8'd0;
    for (int v = 0; v < 2; v++) begin
      go_cnt = 0; clr_cnt = 0;
      set_job(3, bx[v], by[v]);
      @(negedge clk);
      checks++;
      if (ack !== 4'b1000) begin fails++; $display("FAIL byp_ack[%0d]: got %b want 1000", v, ack); end
      req[3] = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_data !== be[v] || rsp_err !== 1'b0) begin
        fails++; $display("FAIL byp_rsp[%0d]: got vld=%b data=%0d err=%b want 1000/%0d/0",
                          v, rsp_valid, rsp_data, rsp_err, be[v]);
      end
      checks++;
      if (go_cnt != 0 || clr_cnt != 0) begin
        fails++; $display("FAIL byp_engine[%0d]: got go=%0d clr=%0d want 0/0", v, go_cnt, clr_cnt);
      end
      finish_rsp(3);
      checks++;
      if (rsp_valid !== 4'b0000 || ptr !== 2'd0) begin
        fails++; $display("FAIL byp_release[%0d]: got vld=%b ptr=%0d want 0000/0", v, rsp_valid, ptr);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    checks++;
    if (ptr !== 2'd0) begin fails++; $display("FAIL rr_start_ptr: got %0d want 0", ptr); end
    set_job(0, 8'd48, 8'd36);
    set_job(2, 8'd7, 8'd5);
    wait_ack(0, ok);
    checks++;
    if (!ok || ack !== 4'b0001) begin fails++; $display("FAIL rr_first_ack: got %b want 0001", ack); end
    req[0] = 1'b0;
    wait_rsp(0, 200, ok);
    checks++;
    if (!ok || rsp_data !== 8'd12) begin fails++; $display("FAIL rr_first_data: got %0d want 12", rsp_data); end
    finish_rsp(0);
    checks++;
    if (ptr !== 2'd1) begin fails++; $display("FAIL rr_mid_ptr: got %0d want 1", ptr); end
    wait_ack(2, ok);
    checks++;
    if (!ok || ack !== 4'b0100) begin fails++; $display("FAIL rr_second_ack: got %b want 0100", ack); end
    req[2] = 1'b0;
    wait_rsp(2, 200, ok);
    checks++;
    if (!ok || rsp_data !== 8'd1) begin fails++; $display("FAIL rr_second_data: got %0d want 1", rsp_data); end
    finish_rsp(2);
    checks++;
    if (ptr !== 2'd3) begin fails++; $display("FAIL rr_end_ptr: got %0d want 3", ptr); end
  endtask

  task automatic test_watchdog();
    bit ok;
    hang = 1'b1;
    go_cnt = 0;
    set_job(1, 8'd9, 8'd6);
    wait_ack(1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL wd_ack: got no ack[1] want ack"); end
    req[1] = 1'b0;
    wait_cnt = 0;
    wait_rsp(1, 1200, ok);
    checks++;
    if (!ok || rsp_err !== 1'b1 || rsp_data !== 8'd0) begin
      fails++; $display("FAIL wd_expire: got seen=%b err=%b data=%0d want 1/1/0", ok, rsp_err, rsp_data);
    end
    checks++;
    if (wait_cnt != MC || go_cnt != 1) begin
      fails++; $display("FAIL wd_cycles: got wait=%0d go=%0d want %0d/1", wait_cnt, go_cnt, MC);
    end
    finish_rsp(1);
    hang = 1'b0;
    set_job(2, 8'd10, 8'd4);
    wait_ack(2, ok);
    checks++;
    if (!ok || ack !== 4'b0100) begin fails++; $display("FAIL wd_next_ack: got %b want 0100", ack); end
    req[2] = 1'b0;
    wait_rsp(2, 200, ok);
    checks++;
    if (!ok || rsp_data !== 8'd2 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL wd_next_data: got data=%0d err=%b want 2/0", rsp_data, rsp_err);
    end
    finish_rsp(2);
  endtask

  task automatic test_hold();
    bit ok;
    int bad;
    set_job(0, 8'd0, 8'd9);
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin fails++; $display("FAIL hold_ack: got %b want 0001", ack); end
    req[0] = 1'b0;
    set_job(1, 8'd5, 8'd0);
    wait_rsp(0, 5, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL hold_rsp: got no rsp_valid[0] want valid"); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      rsp_ready[1] = (c == 4);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 8'd9 || ack !== 4'b0000) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got vld=%b data=%0d ack=%b want 0001/9/0000", c, rsp_valid, rsp_data, ack);
      end
    end
    rsp_ready[1] = 1'b0;
    finish_rsp(0);
    wait_ack(1, ok);
    checks++;
    if (!ok || ack !== 4'b0010) begin fails++; $display("FAIL hold_next_ack: got %b want 0010", ack); end
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 8'd5) begin
      fails++; $display("FAIL hold_next_data: got vld=%b data=%0d want 0010/5", rsp_valid, rsp_data);
    end
    finish_rsp(1);
  endtask

  task automatic test_clr_in_wait();
    bit ok;
    hang = 1'b1;
    set_job(2, 8'd9, 8'd6);
    wait_ack(2, ok);
    req[2] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (state == S_WAIT) ok = 1'b1;
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL clr_reach_wait: got state=%0d want %0d", state, S_WAIT); end
    repeat (3) @(negedge clk);
    ack_cnt = 0;
    clr = 1'b1;
    #1;
    checks++;
    if (eng_clr !== 1'b1) begin fails++; $display("FAIL clr_eng_clr: got %b want 1", eng_clr); end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if ({ack, rsp_valid, rsp_data, rsp_err, eng_go, eng_x, eng_y} !== '0 || ptr !== 2'd0 || state !== S_IDLE) begin
      fails++;
      $display("FAIL clr_outputs: got ack=%b vld=%b data=%0d err=%b go=%b x=%0d y=%0d ptr=%0d st=%0d want all 0",
               ack, rsp_valid, rsp_data, rsp_err, eng_go, eng_x, eng_y, ptr, state);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || ack_cnt != 0) begin
      fails++; $display("FAIL clr_silent: got vld=%b acks=%0d want 0000/0", rsp_valid, ack_cnt);
    end
    hang = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_engine_job();
    test_bypass();
    test_round_robin();
    test_watchdog();
    test_hold();
    test_clr_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
